// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM arbiter: bus widths, frame geometry,
// grant-source and clear-FSM encodings.
package sram_pkg;

  localparam int ADDR_W      = 18;
  localparam int DATA_W      = 16;
  localparam int FRAME_W     = 320;
  localparam int FRAME_H     = 240;
  localparam int CLEAR_WORDS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_CLR,
    GNT_WR
  } grant_e;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  // Counter width for a given word count; never narrower than one bit.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Frame-clear sequencer: walks addresses 0..CLEAR_WORDS-1, requesting one
// SRAM slot per word and advancing only when the arbiter grants that slot.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int ADDR_W      = sram_pkg::ADDR_W,
  parameter int CLEAR_WORDS = sram_pkg::CLEAR_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              gnt_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int             CNT_W = cnt_width(CLEAR_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLEAR_WORDS - 1);

  clr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // NOTE: sequential state is updated with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // A restart wins over a granted word; a lost slot leaves cnt_q alone.
        if (start_i) begin
          cnt_d = '0;
        end else if (gnt_i) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_o  = (state_q == CLEAR);
  assign busy_o = (state_q == CLEAR);
  assign addr_o = ADDR_W'(cnt_q);
  assign done_o = done_q;

endmodule

// File: rtl/sram_arbiter.sv
// Single-port async SRAM arbiter: one registered access per clock, priority
// display read > frame clear > game write. Owns address, WE_N and DQ tri-state.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int                ADDR_W      = sram_pkg::ADDR_W,
  parameter int                DATA_W      = sram_pkg::DATA_W,
  parameter int                CLEAR_WORDS = sram_pkg::CLEAR_WORDS,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  inout  wire  [DATA_W-1:0] sram_dq
);

  grant_e            gnt;
  logic              clr_req;
  logic [ADDR_W-1:0] clr_addr;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_n_q, we_n_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_ack_q, wr_ack_d;

  sram_clear_seq #(
    .ADDR_W      (ADDR_W),
    .CLEAR_WORDS (CLEAR_WORDS)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .start_i (clr_start),
    .gnt_i   (gnt == GNT_CLR),
    .req_o   (clr_req),
    .addr_o  (clr_addr),
    .busy_o  (clr_busy),
    .done_o  (clr_done)
  );

  // The requester keeps wr_req high through its ack cycle, so a write is
  // never re-granted while wr_ack_q is set.
  always_comb begin
    gnt = GNT_NONE;
    if (rd_req)                     gnt = GNT_RD;
    else if (clr_req)               gnt = GNT_CLR;
    else if (wr_req && !wr_ack_q)   gnt = GNT_WR;
  end

  always_comb begin
    addr_d     = addr_q;
    we_n_d     = 1'b1;
    dq_out_d   = dq_out_q;
    dq_oe_d    = 1'b0;
    rd_pend_d  = 1'b0;
    wr_ack_d   = 1'b0;
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? sram_dq : rd_data_q;
    unique case (gnt)
      GNT_RD: begin
        addr_d    = rd_addr;
        rd_pend_d = 1'b1;
      end
      GNT_CLR: begin
        addr_d   = clr_addr;
        we_n_d   = 1'b0;
        dq_out_d = CLEAR_VALUE;
        dq_oe_d  = 1'b1;
      end
      GNT_WR: begin
        addr_d   = wr_addr;
        we_n_d   = 1'b0;
        dq_out_d = wr_data;
        dq_oe_d  = 1'b1;
        wr_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      we_n_q     <= 1'b1;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      we_n_q     <= we_n_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
    end
  end

  // Output enable follows WE_N exactly, so a read right after a write needs
  // no turnaround cycle.
  assign sram_dq   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wr_ack    = wr_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model on the pins, a slot-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_sram_arbiter;

  localparam int              AW = 18;
  localparam int              DW = 16;
  localparam int              CW = 16;
  localparam logic [DW-1:0]   CV = 16'h0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_start = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, wr_ack, clr_busy, clr_done, sram_we_n;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .CLEAR_WORDS (CW),
    .CLEAR_VALUE (CV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_dq   (sram_dq)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return 16'h5A00 ^ DW'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous SRAM on the pins; OE is tied active, so it drives whenever WE_N is high.
  logic [DW-1:0] mem [0:1023];
  bit            mem_init = 1'b0;
  int            hits [0:CW-1] = '{default: 0};

  assign sram_dq = sram_we_n ? mem[sram_addr[9:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (!sram_we_n) begin
      mem[sram_addr[9:0]] <= sram_dq;
      if (sram_dq == CV && sram_addr < AW'(CW)) hits[sram_addr[3:0]] <= hits[sram_addr[3:0]] + 1;
    end
  end

  // Reference model: decides which requester owns each slot from the
  // priority rules and predicts the pins and handshakes for the next cycle.
  bit            m_ok = 1'b0;
  bit            m_slot = 1'b0;
  logic          m_we_n = 1'b1, m_ack = 1'b0, m_rv = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_rdata = '0, m_dq = '0;
  bit            p_rd = 1'b0, p_wr = 1'b0, clr_on = 1'b0, ref_init = 1'b0;
  int            p_rd_a = 0, p_wr_a = 0, clr_next = 0;
  logic [DW-1:0] p_wr_d = '0;
  logic [DW-1:0] ref_mem [0:1023];

  task automatic model_write(input int a, input logic [DW-1:0] d);
    m_slot = 1'b1;
    m_addr = AW'(a);
    m_we_n = 1'b0;
    m_dq   = d;
    p_wr   = 1'b1;
    p_wr_a = a % 1024;
    p_wr_d = d;
  endtask

  always @(posedge clk) begin
    bit rv_new;
    bit prev_ack;
    if (!ref_init) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    rv_new = p_rd;
    if (p_rd) m_rdata = ref_mem[p_rd_a];
    if (p_wr) ref_mem[p_wr_a] = p_wr_d;
    prev_ack = m_ack;
    p_rd = 1'b0; p_wr = 1'b0; m_we_n = 1'b1; m_ack = 1'b0; m_done = 1'b0; m_slot = 1'b0;
    if (rst) begin
      m_rdata = '0; m_rv = 1'b0; m_addr = '0; clr_on = 1'b0; clr_next = 0; m_busy = 1'b0;
      m_ok = 1'b1;
    end else begin
      m_rv = rv_new;
      if (rd_req) begin
        m_slot = 1'b1;
        m_addr = rd_addr;
        p_rd   = 1'b1;
        p_rd_a = int'(rd_addr) % 1024;
      end else if (clr_on) begin
        model_write(clr_next, CV);
        if (clr_next == CW - 1) begin
          clr_on = 1'b0;
          m_done = 1'b1;
        end else begin
          clr_next++;
        end
      end else if (wr_req && !prev_ack) begin
        model_write(int'(wr_addr), wr_data);
        m_ack = 1'b1;
      end
      if (clr_start) begin
        clr_on = 1'b1; clr_next = 0; m_done = 1'b0;
      end
      m_busy = clr_on;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("we_n", sram_we_n, m_we_n);
      check("wr_ack", wr_ack, m_ack);
      check("rd_valid", rd_valid, m_rv);
      check("clr_busy", clr_busy, m_busy);
      check("clr_done", clr_done, m_done);
      if (m_slot) check("sram_addr", sram_addr, m_addr);
      if (!m_we_n) check("dq_write", sram_dq, m_dq);
      if (m_rv) check("rd_data", rd_data, m_rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_cnt, acks, max_lat, present_at, k, done_cnt, done_at, ack_at;
    bit pending_update;
    int base [0:CW-1];

    // Reset state
    repeat (3) tick();
    check("rst_we_n", sram_we_n, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    rst = 1'b0;
    tick();

    // Single write then read back
    wr_req = 1'b1; wr_addr = 18'h00010; wr_data = 16'hBEEF;
    tick();
    check("w1_ack", wr_ack, 1);
    check("w1_we_n", sram_we_n, 0);
    check("w1_addr", sram_addr, 18'h00010);
    check("w1_dq", sram_dq, 16'hBEEF);
    tick();
    check("w1_ack_once", wr_ack, 0);
    check("w1_we_n_once", sram_we_n, 1);
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 18'h00010;
    tick();
    rd_req = 1'b0;
    check("r1_slot_we_n", sram_we_n, 1);
    check("r1_slot_addr", sram_addr, 18'h00010);
    check("r1_not_yet", rd_valid, 0);
    tick();
    check("r1_valid", rd_valid, 1);
    check("r1_data", rd_data, 16'hBEEF);
    tick();
    check("r1_pulse", rd_valid, 0);

    // Collision: read wins, write follows
    rd_req = 1'b1; rd_addr = 18'h00005;
    wr_req = 1'b1; wr_addr = 18'h00005; wr_data = 16'h1234;
    tick();
    rd_req = 1'b0;
    check("col_ack_deferred", wr_ack, 0);
    check("col_rd_we_n", sram_we_n, 1);
    check("col_dq_released", sram_dq, init_val(5));
    tick();
    check("col_ack", wr_ack, 1);
    check("col_wr_we_n", sram_we_n, 0);
    check("col_rd_valid", rd_valid, 1);
    check("col_rd_old", rd_data, init_val(5));
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 18'h00005;
    tick();
    rd_req = 1'b0;
    tick();
    check("col_rd_new_valid", rd_valid, 1);
    check("col_rd_new", rd_data, 16'h1234);
    repeat (2) tick();

    // Display pattern: reads every other cycle, writes held continuously
    rv_cnt = 0; acks = 0; max_lat = 0; present_at = -1; k = 0; pending_update = 1'b0;
    wr_req = 1'b1; wr_addr = 18'h00100; wr_data = 16'h1000;
    for (int i = 0; i < 640; i++) begin
      rd_req  = (i % 2 == 0);
      rd_addr = AW'(32'h100 + (i / 2) % 64);
      tick();
      if (rd_valid) rv_cnt++;
      if (pending_update) begin
        k++;
        wr_addr = AW'(32'h100 + k % 64);
        wr_data = DW'(32'h1000 + k);
        present_at = i;
        pending_update = 1'b0;
      end
      if (wr_ack) begin
        acks++;
        if (i - present_at > max_lat) max_lat = i - present_at;
        pending_update = 1'b1;
      end
    end
    rd_req = 1'b0;
    tick(); if (rd_valid) rv_cnt++;
    wr_req = 1'b0;
    tick(); if (rd_valid) rv_cnt++;
    tick(); if (rd_valid) rv_cnt++;
    check("disp_rd_pulses", rv_cnt, 320);
    check("disp_ack_within_2", (max_lat >= 1 && max_lat <= 2), 1);
    check("disp_writes_progress", (acks >= 300), 1);
    repeat (2) tick();

    // Clear with reads every third cycle; game write waits for the clear
    for (int a = 0; a < CW; a++) base[a] = hits[a];
    done_cnt = 0; done_at = -1; ack_at = -1;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("clr_busy_start", clr_busy, 1);
    wr_req = 1'b1; wr_addr = 18'h00200; wr_data = 16'hC0DE;
    for (int i = 0; i < 100; i++) begin
      rd_req  = (i % 3 == 0);
      rd_addr = AW'(32'h300 + i);
      tick();
      if (ack_at >= 0) wr_req = 1'b0;
      if (clr_done) begin done_cnt++; done_at = i; end
      if (wr_ack && ack_at < 0) ack_at = i;
      if (done_cnt > 0 && ack_at >= 0 && i > ack_at + 3) break;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) tick();
    check("clr_done_once", done_cnt, 1);
    check("clr_wr_after_done", (ack_at >= 0 && ack_at > done_at), 1);
    for (int a = 0; a < CW; a++) check($sformatf("clr_hit_%0d", a), hits[a] - base[a], 1);
    check("clr_no_wrap", mem[16], 16'hBEEF);

    // Reset mid-clear at counter 7 with a read in flight and a write pending
    for (int a = 0; a < CW; a++) base[a] = hits[a];
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    begin
      bit seen6 = 1'b0;
      for (int i = 0; i < 40 && !seen6; i++) begin
        tick();
        if (!sram_we_n && sram_addr == 18'd6) seen6 = 1'b1;
      end
      check("mid_reached_6", seen6, 1);
    end
    rd_req = 1'b1; rd_addr = 18'h00040;
    tick();
    check("mid_read_slot", sram_we_n, 1);
    rd_req = 1'b0; rst = 1'b1; wr_req = 1'b1; wr_addr = 18'h00050; wr_data = 16'h7777;
    tick();
    check("mid_rst_we_n", sram_we_n, 1);
    check("mid_rst_addr", sram_addr, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_ack", wr_ack, 0);
    check("mid_rst_busy", clr_busy, 0);
    check("mid_rst_done", clr_done, 0);
    tick();
    check("mid_rst_no_stray_rv", rd_valid, 0);
    check("mid_rst_no_stray_ack", wr_ack, 0);
    rst = 1'b0; wr_req = 1'b0;
    for (int a = 0; a < CW; a++) base[a] = hits[a];
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("re_busy", clr_busy, 1);
    tick();
    check("re_first_we_n", sram_we_n, 0);
    check("re_first_addr", sram_addr, 0);
    done_cnt = 0;
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      tick();
      if (clr_done) done_cnt++;
    end
    check("re_done", done_cnt, 1);
    repeat (2) tick();
    for (int a = 0; a < CW; a++) check($sformatf("re_hit_%0d", a), hits[a] - base[a], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the board's single-port asynchronous SRAM (16-bit data, 18-bit address) between three requesters, one access per clock.
- Requesters, in priority order:
  1. Display pixel-fetch read port.
  2. Built-in clear sequencer that fills the frame region.
  3. Game-logic write port.
- Sits between the drawer/game logic and the SRAM pins. Owns SRAM_ADDR, SRAM_WE_N and the SRAM_DQ tri-state. UB/LB/CE/OE stay tied low at top level.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- CLEAR_WORDS, 76800, number of words the clear sequencer writes (320x240 frame).
- CLEAR_VALUE, 16'h0000, word written by the clear sequencer.

Ports:
- clk  in  1  pixel clock (25.2 MHz domain); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  display read request for this cycle.
- rd_addr  in  ADDR_W  display read address.
- rd_data  out  DATA_W  read data, valid when rd_valid=1.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- wr_req  in  1  game write request; held until wr_ack.
- wr_addr  in  ADDR_W  game write address.
- wr_data  in  DATA_W  game write data.
- wr_ack  out  1  one-cycle pulse: write issued this cycle.
- clr_start  in  1  pulse: begin clearing.
- clr_busy  out  1  clear sequencer active.
- clr_done  out  1  one-cycle pulse after the last clear word is issued.
- sram_addr  out  ADDR_W  SRAM address pins.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_dq  inout  DATA_W  SRAM data bus.

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high on rst.
- Reset values:
  - sram_addr=0, sram_we_n=1, DQ released (high-Z).
  - rd_valid=0, rd_data=0, wr_ack=0.
  - clr_busy=0, clr_done=0, clear counter=0, FSM=IDLE.
- Access slots and arbitration:
  - Each cycle issues at most one access. sram_addr, sram_we_n, DQ output data and DQ output enable are registered.
  - Priority is rd_req > clear sequencer > wr_req.
  - A slot lost by the clear sequencer retries the same address the next cycle.
- Read path:
  - Read granted at edge N drives sram_addr=rd_addr with we_n=1 during cycle N+1.
  - rd_data captures sram_dq at edge N+2, with rd_valid=1 for that one cycle.
  - Fixed latency: 2 cycles from request to rd_valid.
  - Reads are never refused; back-to-back reads are permitted.
- Write path:
  - Write granted at edge N drives sram_addr/data with we_n=0 and the DQ output enable on during cycle N+1.
  - wr_ack=1 for exactly the cycle following grant (cycle N+1).
  - The requester may drop wr_req or present the next write on the cycle after the ack.
  - wr_req held while not granted: the request simply waits; no starvation counter.
  - The display reads at most every other cycle (pixel doubling), so writes always progress.
- DQ output enable is asserted only in write slots. A read immediately after a write is legal; there is no turnaround bubble.
- FSM:
  - States are IDLE and CLEAR.
  - IDLE→CLEAR on clr_start: counter=0, clr_busy=1.
  - In CLEAR, each clear slot writes CLEAR_VALUE at address=counter, then the counter increments.
  - CLEAR→IDLE when the word at address CLEAR_WORDS-1 is issued. clr_done pulses one cycle and clr_busy drops the same cycle.
  - wr_req is not granted while clr_busy=1.
- clr_start while already in CLEAR restarts the counter at 0.
- rst mid-clear or mid-access aborts the operation:
  - Outputs return to their reset values on the next edge.
  - An in-flight read produces no rd_valid.
- Counter width is ceil(log2(CLEAR_WORDS)). Compare against CLEAR_WORDS-1; never wrap past it.
- Simultaneous rd_req and wr_req: the read wins; wr_ack is deferred.

Decomposition:
- Shared package sram_pkg:
  - ADDR_W / DATA_W constants.
  - Frame geometry constants (320, 240, CLEAR_WORDS).
  - Enum for grant source {GNT_NONE, GNT_RD, GNT_CLR, GNT_WR}.
  - Enum for FSM state {IDLE, CLEAR}.
- One natural sub-module: sram_clear_seq (counter, FSM, clr_busy/clr_done, request/advance handshake with the arbiter).

Test Plan:
- Single write then read: wr_req addr=0x00010 data=0xBEEF.
  - wr_ack one cycle later; sram_we_n=0 for exactly one cycle.
  - Then rd_req addr=0x00010: rd_valid two cycles later with rd_data=0xBEEF (SRAM model).
- Collision: rd_req and wr_req asserted together at addr 0x00005.
  - Read slot first; wr_ack in the following slot.
  - DQ never driven during the read slot.
- Display pattern: rd_req every other cycle for 640 cycles with wr_req held continuously.
  - Every write acked within 2 cycles.
  - Exactly 320 rd_valid pulses.
- Clear with CLEAR_WORDS=16 and reads every third cycle:
  - Addresses 0..15 each written once with 0x0000.
  - clr_done pulses once; wr_req stays unacked until clr_busy=0.
- Reset mid-clear at counter=7, then clr_start again:
  - Outputs return to reset values; no stray rd_valid or wr_ack.
  - Clear restarts at address 0.
